// File: rtl/tpu_pkg.sv
// Shared constants, drain FSM state encoding and the saturating-add width rule
// used by the systolic-array output buffer.
package tpu_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int LANES_DEF      = 4;
  localparam int DEPTH_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } drain_state_t;

  // One guard bit is enough to detect overflow of a two-operand signed add.
  function automatic int sat_sum_width(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational signed add clamped to the representable DATA_WIDTH range.
module sat_adder
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic signed [DATA_WIDTH-1:0] o_sum
);

  localparam int SW = sat_sum_width(DATA_WIDTH);

  logic signed [SW-1:0] w_wide;

  // Widen, add, then clamp when the guard bit disagrees with the sign bit.
  always_comb begin
    w_wide = {i_a[DATA_WIDTH-1], i_a} + {i_b[DATA_WIDTH-1], i_b};
    if (w_wide[SW-1] != w_wide[SW-2]) begin
      if (w_wide[SW-1]) begin
        o_sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        o_sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end else begin
      o_sum = w_wide[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/output_acc_buffer.sv
// Multi-lane result buffer: row writes with optional saturating accumulate,
// and a drain FSM streaming selected rows word by word over valid/ready.
module output_acc_buffer
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ROW_AW     = $clog2(DEPTH),
  parameter int LANE_AW    = $clog2(LANES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [ROW_AW-1:0]           wr_row,
  input  logic [LANES*DATA_WIDTH-1:0] wr_data,
  input  logic [LANES-1:0]            wr_mask,
  input  logic                        acc_mode,
  input  logic                        clear,
  input  logic                        drain_start,
  input  logic [ROW_AW-1:0]           drain_base,
  input  logic [ROW_AW:0]             drain_rows,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int TW = ROW_AW + LANE_AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH][LANES];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      w_valid_nxt;

  logic                  w_wr_any;
  logic                  w_row_live;
  logic [DATA_WIDTH-1:0] w_old [LANES];
  logic [DATA_WIDTH-1:0] w_sum [LANES];
  logic [DATA_WIDTH-1:0] w_new [LANES];

  drain_state_t          r_state;
  logic [ROW_AW-1:0]     r_nrow;
  logic [LANE_AW-1:0]    r_nlane;
  logic [TW-1:0]         r_left;

  logic [ROW_AW-1:0]     w_rd_row;
  logic [LANE_AW-1:0]    w_rd_lane;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [ROW_AW-1:0]     w_adv_row;
  logic [LANE_AW-1:0]    w_adv_lane;
  logic [TW-1:0]         w_total;

  assign w_wr_any   = wr_en & (|wr_mask);
  // A clear in the same cycle makes the row's previous contents count as zero.
  assign w_row_live = r_valid[wr_row] & ~clear;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      assign w_old[g] = w_row_live ? r_mem[wr_row][g] : {DATA_WIDTH{1'b0}};

      sat_adder #(.DATA_WIDTH(DATA_WIDTH)) u_sat (
        .i_a   (w_old[g]),
        .i_b   (wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
        .o_sum (w_sum[g])
      );

      assign w_new[g] = acc_mode ? w_sum[g] : wr_data[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Row storage; masked-off lanes of a freshly validated row are zeroed.
  always_ff @(posedge clk) begin
    if (w_wr_any) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) begin
          r_mem[wr_row][i] <= w_new[i];
        end else if (!w_row_live) begin
          r_mem[wr_row][i] <= {DATA_WIDTH{1'b0}};
        end
      end
    end
  end

  always_comb begin
    w_valid_nxt         = clear ? {DEPTH{1'b0}} : r_valid;
    w_valid_nxt[wr_row] = w_valid_nxt[wr_row] | w_wr_any;
  end

  // Row-valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= {DEPTH{1'b0}};
    end else begin
      r_valid <= w_valid_nxt;
    end
  end

  // The first word comes from drain_base; later words from the stored pointer.
  assign w_rd_row   = (r_state == ST_IDLE) ? drain_base : r_nrow;
  assign w_rd_lane  = (r_state == ST_IDLE) ? {LANE_AW{1'b0}} : r_nlane;
  assign w_rd_data  = r_valid[w_rd_row] ? r_mem[w_rd_row][w_rd_lane] : {DATA_WIDTH{1'b0}};
  assign w_adv_lane = w_rd_lane + LANE_AW'(1);
  assign w_adv_row  = (w_rd_lane == LANE_AW'(LANES - 1)) ? (w_rd_row + ROW_AW'(1)) : w_rd_row;
  assign w_total    = TW'(drain_rows) << LANE_AW;

  // Drain FSM with registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_nrow    <= {ROW_AW{1'b0}};
      r_nlane   <= {LANE_AW{1'b0}};
      r_left    <= {TW{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {DATA_WIDTH{1'b0}};
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (drain_start) begin
            if (drain_rows != {(ROW_AW+1){1'b0}}) begin
              out_data  <= w_rd_data;
              out_valid <= 1'b1;
              out_last  <= (w_total == TW'(1));
              r_nrow    <= w_adv_row;
              r_nlane   <= w_adv_lane;
              r_left    <= w_total - TW'(1);
              busy      <= 1'b1;
              r_state   <= ST_STREAM;
            end else begin
              done    <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_STREAM: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              out_data <= w_rd_data;
              out_last <= (r_left == TW'(1));
              r_nrow   <= w_adv_row;
              r_nlane  <= w_adv_lane;
              r_left   <= r_left - TW'(1);
            end
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
